// File: rtl/fetch_unit_if.sv
// fetch_unit_if
//   Bundles the instruction-memory read port and the issue-side handshake of
//   the fetch unit.
//   Memory port : imem_read, imem_addr (fetch side out), imem_rdata, imem_resp (memory out)
//   Issue port  : instr, curr_pc, instr_is_new (fetch side out), stall, pcmux_sel, br_pc (issue out)
//   ROB flush   : flush, flush_pc (ROB out)
//   master : fetch unit side
//   slave  : environment side (memory, issue control, ROB)
interface fetch_unit_if;
    logic        imem_read;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_resp;
    logic [15:0] instr;
    logic [15:0] curr_pc;
    logic        instr_is_new;
    logic        stall;
    logic        pcmux_sel;
    logic [15:0] br_pc;
    logic        flush;
    logic [15:0] flush_pc;

    modport master (
        output imem_read, imem_addr, instr, curr_pc, instr_is_new,
        input  imem_rdata, imem_resp, stall, pcmux_sel, br_pc, flush, flush_pc
    );

    modport slave (
        input  imem_read, imem_addr, instr, curr_pc, instr_is_new,
        output imem_rdata, imem_resp, stall, pcmux_sel, br_pc, flush, flush_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit
//   Front-end fetch stage. Issues one outstanding 16-bit read at a time to the
//   instruction memory, buffers responses in an in-order queue of
//   {instr, pc+2}, and presents the queue head to issue. Predicted-taken
//   redirects (on a consumed head) and ROB flushes clear the queue and restart
//   fetch; a read still in flight at that moment is drained and its data dropped.
//   Ports:
//     clk  : clock, rising edge
//     rst  : synchronous active-high reset
//     bus  : fetch_unit_if.master (memory read port, issue handshake, flush)
//   Parameters:
//     QUEUE_DEPTH : queue entries, power of 2, >= 2
//     PC_RESET    : fetch PC after reset
//   Build option:
//     FETCH_BYPASS_EN : when defined, a response arriving at an empty queue is
//                       presented to issue in the same cycle.
module fetch_unit #(
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter logic [15:0] PC_RESET    = 16'h0000
) (
    input logic          clk,
    input logic          rst,
    fetch_unit_if.master bus
);
    localparam int unsigned     PtrW = $clog2(QUEUE_DEPTH);
    localparam int unsigned     CntW = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [CntW-1:0] Full = CntW'(QUEUE_DEPTH);

    typedef enum logic [1:0] {StIdle, StFetch, StDiscard} state_e;

    state_e          state_q;
    logic [15:0]     fetch_pc_q;
    logic [15:0]     addr_q;
    logic            read_q;
    logic [15:0]     last_instr_q;
    logic [15:0]     last_pc_q;
    logic [15:0]     q_instr [QUEUE_DEPTH];
    logic [15:0]     q_pc    [QUEUE_DEPTH];
    logic [PtrW-1:0] head_q;
    logic [PtrW-1:0] tail_q;
    logic [CntW-1:0] count_q;

    logic            q_empty;
    logic            resp_fetch;
    logic            bypass;
    logic            head_valid;
    logic            consume;
    logic            kill;
    logic            push;
    logic            pop;
    logic [15:0]     kill_pc;
    logic [15:0]     instr_out;
    logic [15:0]     curr_pc_out;
    logic [CntW-1:0] count_next;

    always_comb begin
        q_empty    = (count_q == '0);
        resp_fetch = (state_q == StFetch) && bus.imem_resp;
`ifdef FETCH_BYPASS_EN
        bypass     = q_empty && resp_fetch;
`else
        bypass     = 1'b0;
`endif
        head_valid  = !q_empty || bypass;
        instr_out   = last_instr_q;
        curr_pc_out = last_pc_q;
        if (!q_empty) begin
            instr_out   = q_instr[head_q];
            curr_pc_out = q_pc[head_q];
        end else if (bypass) begin
            instr_out   = bus.imem_rdata;
            curr_pc_out = fetch_pc_q + 16'd2;
        end
        consume = head_valid && !bus.stall;
        // Flush wins over redirect, push and pop.
        kill    = bus.flush || (consume && bus.pcmux_sel);
        kill_pc = bus.flush ? bus.flush_pc : bus.br_pc;
        pop     = consume && !q_empty;
        // A bypassed response that issue takes immediately never enters the queue.
        push       = resp_fetch && !(bypass && consume);
        count_next = count_q + CntW'(push) - CntW'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            fetch_pc_q   <= PC_RESET;
            addr_q       <= PC_RESET;
            read_q       <= 1'b0;
            last_instr_q <= '0;
            last_pc_q    <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
        end else begin
            // Remember what issue last saw so an empty queue holds its outputs.
            if (head_valid) begin
                last_instr_q <= instr_out;
                last_pc_q    <= curr_pc_out;
            end
            if (push) begin
                q_instr[tail_q] <= bus.imem_rdata;
                q_pc[tail_q]    <= fetch_pc_q + 16'd2;
            end
            if (kill) begin
                head_q     <= '0;
                tail_q     <= '0;
                count_q    <= '0;
                fetch_pc_q <= kill_pc;
                if (read_q && !bus.imem_resp) begin
                    // Read still in flight: keep the old address until it completes.
                    state_q <= StDiscard;
                end else begin
                    state_q <= StFetch;
                    read_q  <= 1'b1;
                    addr_q  <= kill_pc;
                end
            end else begin
                if (push) tail_q <= tail_q + 1'b1;
                if (pop)  head_q <= head_q + 1'b1;
                count_q <= count_next;
                case (state_q)
                    StIdle: begin
                        if (count_next < Full) begin
                            state_q <= StFetch;
                            read_q  <= 1'b1;
                            addr_q  <= fetch_pc_q;
                        end
                    end
                    StFetch: begin
                        if (bus.imem_resp) begin
                            fetch_pc_q <= fetch_pc_q + 16'd2;
                            addr_q     <= fetch_pc_q + 16'd2;
                            if (count_next >= Full) begin
                                state_q <= StIdle;
                                read_q  <= 1'b0;
                            end
                        end
                    end
                    StDiscard: begin
                        if (bus.imem_resp) begin
                            state_q <= StFetch;
                            addr_q  <= fetch_pc_q;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                        read_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.imem_read    = read_q;
    assign bus.imem_addr    = addr_q;
    assign bus.instr        = instr_out;
    assign bus.curr_pc      = curr_pc_out;
    assign bus.instr_is_new = head_valid;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit. A memory responder returns mem_word(addr) after a
// configurable latency; the reference model tracks the PC that issue must see
// next (program order, redirect target or flush target) and checks every
// consumed instruction against it.
module tb_fetch_unit;
    localparam logic [15:0] PcReset = 16'h0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_unit_if bus ();

    fetch_unit #(
        .QUEUE_DEPTH(4),
        .PC_RESET   (PcReset)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc_n  = 0;
    int          mem_cnt = 0;
    int          mem_lat = 1;
    int          cur_lat = 1;
    bit          mem_lat_rand = 1'b0;
    logic [15:0] req_addr = '0;
    logic [15:0] exp_pc = PcReset;
    int          req_cyc[$];
    logic [15:0] req_adr[$];
    int          rsp_cyc[$];
    int          con_cyc[$];
    logic [15:0] con_pc[$];

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return 16'h1234 ^ (a * 16'h0B35);
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one cycle and play the memory for it.
    task automatic edge_mem(input logic r);
        @(posedge clk);
        #1;
        cyc_n++;
        rst = r;
        if (!bus.imem_read) begin
            mem_cnt = 0;
            bus.imem_resp = 1'b0;
            bus.imem_rdata = 16'($urandom);
        end else begin
            if (mem_cnt == 0) begin
                req_addr = bus.imem_addr;
                req_cyc.push_back(cyc_n);
                req_adr.push_back(bus.imem_addr);
                cur_lat = mem_lat_rand ? int'($urandom_range(0, 3)) : mem_lat;
            end else begin
                chk("addr_hold", bus.imem_addr, req_addr);
            end
            if (mem_cnt >= cur_lat) begin
                bus.imem_resp  = 1'b1;
                bus.imem_rdata = mem_word(req_addr);
                rsp_cyc.push_back(cyc_n);
                mem_cnt = 0;
            end else begin
                bus.imem_resp  = 1'b0;
                bus.imem_rdata = 16'($urandom);
                mem_cnt++;
            end
        end
    endtask

    // Drive issue/ROB inputs for the cycle and run the reference model.
    task automatic drive_obs(input logic s, input logic p, input logic [15:0] b,
                             input logic f, input logic [15:0] fp);
        bus.stall = s;
        bus.pcmux_sel = p;
        bus.br_pc = b;
        bus.flush = f;
        bus.flush_pc = fp;
        #1;
        if (rst) begin
            exp_pc = PcReset;
        end else begin
            if (bus.instr_is_new && !s) begin
                chk("instr", bus.instr, mem_word(exp_pc));
                chk("curr_pc", bus.curr_pc, exp_pc + 16'd2);
                con_cyc.push_back(cyc_n);
                con_pc.push_back(bus.curr_pc);
                exp_pc = p ? b : exp_pc + 16'd2;
            end
            if (f) exp_pc = fp;
        end
    endtask

    task automatic cyc(input logic s, input logic p, input logic [15:0] b,
                       input logic f, input logic [15:0] fp);
        edge_mem(1'b0);
        drive_obs(s, p, b, f, fp);
    endtask

    task automatic rcyc();
        edge_mem(1'b1);
        drive_obs(1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
    endtask

    task automatic do_reset();
        rcyc();
        rcyc();
        req_cyc.delete();
        req_adr.delete();
        rsp_cyc.delete();
        con_cyc.delete();
        con_pc.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        int n;
        int bad;
        bit hit;
        rst = 1'b1;
        bus.stall = 1'b1;
        bus.pcmux_sel = 1'b0;
        bus.br_pc = '0;
        bus.flush = 1'b0;
        bus.flush_pc = '0;
        bus.imem_resp = 1'b0;
        bus.imem_rdata = '0;

        // Reset values
        do_reset();
        chk("rst_read", 16'(bus.imem_read), 16'd0);
        chk("rst_addr", bus.imem_addr, PcReset);
        chk("rst_instr", bus.instr, 16'h0000);
        chk("rst_curr_pc", bus.curr_pc, 16'h0000);
        chk("rst_is_new", 16'(bus.instr_is_new), 16'd0);

        // Sequential fetch, latency 1
        mem_lat = 1;
        cyc(0, 0, 0, 0, 0);
        a0 = cyc_n;
        chk("first_req_early", 16'(bus.imem_read), 16'd0);
        cyc(0, 0, 0, 0, 0);
        chk("first_req_read", 16'(bus.imem_read), 16'd1);
        chk("first_req_addr", bus.imem_addr, 16'h0000);
        for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0, 0);
        chk("seq_nreq", 16'(req_adr.size() >= 3), 16'd1);
        chk("seq_ncon", 16'(con_pc.size() >= 3), 16'd1);
        chk("seq_req0", req_adr[0], 16'h0000);
        chk("seq_req1", req_adr[1], 16'h0002);
        chk("seq_req2", req_adr[2], 16'h0004);
        chk("seq_req0_cyc", 16'(req_cyc[0] - a0), 16'd1);
        chk("seq_con0", con_pc[0], 16'h0002);
        chk("seq_con1", con_pc[1], 16'h0004);
        chk("seq_con2", con_pc[2], 16'h0006);
        chk("seq_gap01", 16'(con_cyc[1] - con_cyc[0]), 16'd2);
        chk("seq_gap12", 16'(con_cyc[2] - con_cyc[1]), 16'd2);
`ifdef FETCH_BYPASS_EN
        chk("fetch_latency", 16'(con_cyc[0] - rsp_cyc[0]), 16'd0);
`else
        chk("fetch_latency", 16'(con_cyc[0] - rsp_cyc[0]), 16'd1);
`endif

        // Fill to full with stall held
        do_reset();
        for (int i = 0; i < 14; i++) cyc(1, 0, 0, 0, 0);
        chk("full_read", 16'(bus.imem_read), 16'd0);
        chk("full_nresp", 16'(rsp_cyc.size()), 16'd4);
        chk("full_nreq", 16'(req_adr.size()), 16'd4);
        chk("full_is_new", 16'(bus.instr_is_new), 16'd1);
        cyc(0, 0, 0, 0, 0);
        chk("full_pop_read", 16'(bus.imem_read), 16'd0);
        cyc(1, 0, 0, 0, 0);
        chk("full_restart_read", 16'(bus.imem_read), 16'd1);
        chk("full_restart_addr", bus.imem_addr, 16'h0008);

        // Predicted-taken redirect with a full queue at 0x0010..0x0016
        do_reset();
        cyc(1, 0, 0, 1, 16'h0010);
        for (int i = 0; i < 14; i++) cyc(1, 0, 0, 0, 0);
        chk("redir_head", bus.curr_pc, 16'h0012);
        con_pc.delete();
        cyc(0, 1, 16'h0040, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("redir_read", 16'(bus.imem_read), 16'd1);
        chk("redir_addr", bus.imem_addr, 16'h0040);
        chk("redir_empty", 16'(bus.instr_is_new), 16'd0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0);
        chk("redir_ncon", 16'(con_pc.size() >= 2), 16'd1);
        chk("redir_first", con_pc[1], 16'h0042);
        bad = 0;
        foreach (con_pc[i]) if (con_pc[i] == 16'h0014) bad++;
        chk("redir_no_wrong_path", 16'(bad), 16'd0);

        // Redirect two cycles into a latency-5 read at 0x0020
        do_reset();
        mem_lat = 5;
        cyc(1, 0, 0, 1, 16'h001E);
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            cyc(1, 0, 0, 0, 0);
            if (req_adr.size() > 0 && req_adr[$] == 16'h0020 && req_cyc[$] == cyc_n) hit = 1'b1;
        end
        chk("disc_wait_req", 16'(hit), 16'd1);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 16'h0080, 0, 0);
        hit = 1'b0;
        for (int i = 0; i < 10 && !hit; i++) begin
            cyc(0, 0, 0, 0, 0);
            chk("disc_addr_held", bus.imem_addr, 16'h0020);
            if (bus.imem_resp) hit = 1'b1;
        end
        chk("disc_resp_seen", 16'(hit), 16'd1);
        cyc(0, 0, 0, 0, 0);
        chk("disc_restart_read", 16'(bus.imem_read), 16'd1);
        chk("disc_restart_addr", bus.imem_addr, 16'h0080);
        chk("disc_dropped", 16'(bus.instr_is_new), 16'd0);
        n = con_pc.size();
        for (int i = 0; i < 15; i++) cyc(0, 0, 0, 0, 0);
        chk("disc_ncon", 16'(con_pc.size() > n), 16'd1);
        chk("disc_first", con_pc[n], 16'h0082);

        // Flush and redirect together while a push arrives
        do_reset();
        mem_lat = 1;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            edge_mem(1'b0);
            if (bus.imem_resp && bus.instr_is_new) begin
                drive_obs(0, 1, 16'h0040, 1, 16'h0100);
                hit = 1'b1;
            end else begin
                drive_obs(1, 0, 0, 0, 0);
            end
        end
        chk("flush_hit", 16'(hit), 16'd1);
        cyc(0, 0, 0, 0, 0);
        chk("flush_read", 16'(bus.imem_read), 16'd1);
        chk("flush_addr", bus.imem_addr, 16'h0100);
        chk("flush_push_dropped", 16'(bus.instr_is_new), 16'd0);
        n = con_pc.size();
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0);
        chk("flush_ncon", 16'(con_pc.size() > n), 16'd1);
        chk("flush_first", con_pc[n], 16'h0102);

        // First response on an empty queue, latency 1
        do_reset();
        hit = 1'b0;
        for (int i = 0; i < 10 && !hit; i++) begin
            cyc(0, 0, 0, 0, 0);
            if (bus.imem_resp) hit = 1'b1;
        end
        chk("first_resp_seen", 16'(hit), 16'd1);
`ifdef FETCH_BYPASS_EN
        chk("byp_instr", bus.instr, 16'h1234);
        chk("byp_curr_pc", bus.curr_pc, 16'h0002);
        chk("byp_is_new", 16'(bus.instr_is_new), 16'd1);
        cyc(0, 0, 0, 0, 0);
        chk("byp_not_pushed", 16'(bus.instr_is_new), 16'd0);
        chk("hold_instr", bus.instr, 16'h1234);
`else
        chk("nobyp_is_new", 16'(bus.instr_is_new), 16'd0);
        cyc(0, 0, 0, 0, 0);
        chk("nobyp_instr", bus.instr, 16'h1234);
        chk("nobyp_curr_pc", bus.curr_pc, 16'h0002);
        chk("nobyp_next_is_new", 16'(bus.instr_is_new), 16'd1);
        cyc(0, 0, 0, 0, 0);
        chk("hold_is_new", 16'(bus.instr_is_new), 16'd0);
        chk("hold_instr", bus.instr, 16'h1234);
`endif

        // Random traffic against the program-order model
        do_reset();
        mem_lat_rand = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                rcyc();
            end else begin
                cyc($urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0,
                    16'($urandom) & 16'hFFFE, $urandom_range(0, 39) == 0,
                    16'($urandom) & 16'hFFFE);
            end
        end
        n = con_pc.size();
        for (int i = 0; i < 40; i++) cyc(0, 0, 0, 0, 0);
        chk("drain_progress", 16'(con_pc.size() > n), 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
